mem_port_scheduler: RTL and testbench

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

---
 rtl/mem_port_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// Two-port (CPU / VGA) arbiter onto a single SDRAM port, one
// transaction outstanding, with CPU anti-starvation ageing.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_m_*             CPU request port (addr/data/access/ack/wr/bsel)
//   mcga_m_*            VGA request port, same shape as CPU port
//   vga_active_display  VGA priority hint
//   sdram_m_*           memory port driven from latched winner request
//   grant_vga           owner of current/last transaction (1=VGA)
//   cpu_starved         CPU has waited AGE_LIMIT or more cycles
module mem_port_scheduler #(
  parameter int AGE_LIMIT = 12,
  parameter int AGE_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] cpu_m_addr,
  input  logic [15:0] cpu_m_data_out,
  output logic [15:0] cpu_m_data_in,
  input  logic        cpu_m_access,
  output logic        cpu_m_ack,
  input  logic        cpu_m_wr_en,
  input  logic [1:0]  cpu_m_bytesel,
  input  logic [19:1] mcga_m_addr,
  input  logic [15:0] mcga_m_data_out,
  output logic [15:0] mcga_m_data_in,
  input  logic        mcga_m_access,
  output logic        mcga_m_ack,
  input  logic        mcga_m_wr_en,
  input  logic [1:0]  mcga_m_bytesel,
  input  logic        vga_active_display,
  output logic [19:1] sdram_m_addr,
  output logic [15:0] sdram_m_data_out,
  input  logic [15:0] sdram_m_data_in,
  output logic        sdram_m_access,
  input  logic        sdram_m_ack,
  output logic        sdram_m_wr_en,
  output logic [1:0]  sdram_m_bytesel,
  output logic        grant_vga,
  output logic        cpu_starved
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

  state_t      state_q, state_d;
  logic        gvga_q, gvga_d;
  logic        rr_vga_q, rr_vga_d;
  logic [19:1] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        wr_q, wr_d;
  logic [1:0]  bsel_q, bsel_d;
  logic        acc_q, acc_d;
  logic [15:0] crd_q, crd_d;
  logic [15:0] vrd_q, vrd_d;
  logic        cack_q, cack_d;
  logic        vack_q, vack_d;
  logic        cmsk_q, cmsk_d;
  logic        vmsk_q, vmsk_d;
  logic [AGE_W-1:0] age_q, age_d;

  logic cpu_req;
  logic vga_req;
  logic pick_any;
  logic pick_vga;
  logic grant_now;
  logic starved;
  logic cpu_owns;

  // A port is masked during its ack cycle and the one after, so a
  // request line that has not dropped yet is not granted twice.
  assign cpu_req  = cpu_m_access & ~(cack_q | cmsk_q);
  assign vga_req  = mcga_m_access & ~(vack_q | vmsk_q);
  assign pick_any = cpu_req | vga_req;
  assign starved  = (age_q >= LIMIT);
  assign cpu_owns = (state_q != IDLE) & ~gvga_q;

  always_comb begin
    pick_vga = 1'b0;
    if (starved && cpu_req) begin
      pick_vga = 1'b0;
    end else if (vga_active_display && vga_req) begin
      pick_vga = 1'b1;
    end else if (cpu_req && vga_req) begin
      pick_vga = rr_vga_q;
    end else begin
      pick_vga = vga_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    gvga_d    = gvga_q;
    rr_vga_d  = rr_vga_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    wr_d      = wr_q;
    bsel_d    = bsel_q;
    acc_d     = acc_q;
    crd_d     = crd_q;
    vrd_d     = vrd_q;
    cack_d    = 1'b0;
    vack_d    = 1'b0;
    cmsk_d    = cack_q;
    vmsk_d    = vack_q;
    grant_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_now = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Memory ack is only honoured here.
        if (sdram_m_ack) begin
          acc_d   = 1'b0;
          state_d = RESP;
          if (gvga_q) begin
            vrd_d  = sdram_m_data_in;
            vack_d = 1'b1;
          end else begin
            crd_d  = sdram_m_data_in;
            cack_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (pick_any) begin
          grant_now = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_now) begin
      gvga_d   = pick_vga;
      rr_vga_d = ~pick_vga;
      acc_d    = 1'b1;
      if (pick_vga) begin
        addr_d = mcga_m_addr;
        wdat_d = mcga_m_data_out;
        wr_d   = mcga_m_wr_en;
        bsel_d = mcga_m_bytesel;
      end else begin
        addr_d = cpu_m_addr;
        wdat_d = cpu_m_data_out;
        wr_d   = cpu_m_wr_en;
        bsel_d = cpu_m_bytesel;
      end
    end
  end

  // Age counts CPU wait cycles; it is cleared while the CPU owns
  // the port, when it is granted, or when it stops asking.
  always_comb begin
    age_d = age_q;
    if (!cpu_m_access || cpu_owns ||
        (grant_now && !pick_vga)) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gvga_q   <= 1'b0;
      rr_vga_q <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      wr_q     <= 1'b0;
      bsel_q   <= '0;
      acc_q    <= 1'b0;
      crd_q    <= '0;
      vrd_q    <= '0;
      cack_q   <= 1'b0;
      vack_q   <= 1'b0;
      cmsk_q   <= 1'b0;
      vmsk_q   <= 1'b0;
      age_q    <= '0;
    end else begin
      state_q  <= state_d;
      gvga_q   <= gvga_d;
      rr_vga_q <= rr_vga_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      wr_q     <= wr_d;
      bsel_q   <= bsel_d;
      acc_q    <= acc_d;
      crd_q    <= crd_d;
      vrd_q    <= vrd_d;
      cack_q   <= cack_d;
      vack_q   <= vack_d;
      cmsk_q   <= cmsk_d;
      vmsk_q   <= vmsk_d;
      age_q    <= age_d;
    end
  end

  assign sdram_m_addr     = addr_q;
  assign sdram_m_data_out = wdat_q;
  assign sdram_m_access   = acc_q;
  // Write strobe only asserted while a write is actually in flight.
  assign sdram_m_wr_en    = wr_q & acc_q;
  assign sdram_m_bytesel  = bsel_q;
  assign cpu_m_data_in    = crd_q;
  assign mcga_m_data_in   = vrd_q;
  assign cpu_m_ack        = cack_q;
  assign mcga_m_ack       = vack_q;
  assign grant_vga        = gvga_q;
  assign cpu_starved      = starved;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: behavioural SDRAM model,
// scoreboard of expected acks, immediate-assertion checks.
module tb_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] cpu_m_addr;
  logic [15:0] cpu_m_data_out;
  logic [15:0] cpu_m_data_in;
  logic        cpu_m_access;
  logic        cpu_m_ack;
  logic        cpu_m_wr_en;
  logic [1:0]  cpu_m_bytesel;
  logic [19:1] mcga_m_addr;
  logic [15:0] mcga_m_data_out;
  logic [15:0] mcga_m_data_in;
  logic        mcga_m_access;
  logic        mcga_m_ack;
  logic        mcga_m_wr_en;
  logic [1:0]  mcga_m_bytesel;
  logic        vga_active_display;
  logic [19:1] sdram_m_addr;
  logic [15:0] sdram_m_data_out;
  logic [15:0] sdram_m_data_in;
  logic        sdram_m_access;
  logic        sdram_m_wr_en;
  logic [1:0]  sdram_m_bytesel;
  logic        grant_vga;
  logic        cpu_starved;
  logic        mem_ack;
  logic        stray_ack;

  always #5 clk = ~clk;

  mem_port_scheduler #(.AGE_LIMIT(12), .AGE_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_m_addr         (cpu_m_addr),
    .cpu_m_data_out     (cpu_m_data_out),
    .cpu_m_data_in      (cpu_m_data_in),
    .cpu_m_access       (cpu_m_access),
    .cpu_m_ack          (cpu_m_ack),
    .cpu_m_wr_en        (cpu_m_wr_en),
    .cpu_m_bytesel      (cpu_m_bytesel),
    .mcga_m_addr        (mcga_m_addr),
    .mcga_m_data_out    (mcga_m_data_out),
    .mcga_m_data_in     (mcga_m_data_in),
    .mcga_m_access      (mcga_m_access),
    .mcga_m_ack         (mcga_m_ack),
    .mcga_m_wr_en       (mcga_m_wr_en),
    .mcga_m_bytesel     (mcga_m_bytesel),
    .vga_active_display (vga_active_display),
    .sdram_m_addr       (sdram_m_addr),
    .sdram_m_data_out   (sdram_m_data_out),
    .sdram_m_data_in    (sdram_m_data_in),
    .sdram_m_access     (sdram_m_access),
    .sdram_m_ack        (mem_ack | stray_ack),
    .sdram_m_wr_en      (sdram_m_wr_en),
    .sdram_m_bytesel    (sdram_m_bytesel),
    .grant_vga          (grant_vga),
    .cpu_starved        (cpu_starved)
  );

  typedef struct {
    bit          vga;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          n_cpu = 0;
  int          n_vga = 0;
  logic [15:0] mem [logic [19:1]];
  int          mem_lat = 2;
  int          mcnt = 0;
  bit          mbusy = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SDRAM model: ack mem_lat cycles after access is first seen.
  always @(posedge clk) begin
    logic [15:0] w;
    #2;
    mem_ack = 1'b0;
    if (sdram_m_access && !reset) begin
      if (!mbusy) begin
        mbusy = 1'b1;
        mcnt  = mem_lat;
      end
      mcnt--;
      if (mcnt == 0) begin
        if (sdram_m_wr_en) begin
          w = mem.exists(sdram_m_addr) ? mem[sdram_m_addr] : 16'h0;
          if (sdram_m_bytesel[0]) w[7:0] = sdram_m_data_out[7:0];
          if (sdram_m_bytesel[1]) w[15:8] = sdram_m_data_out[15:8];
          mem[sdram_m_addr] = w;
        end else begin
          sdram_m_data_in = mem.exists(sdram_m_addr) ?
                            mem[sdram_m_addr] : 16'h0;
        end
        mem_ack = 1'b1;
        mbusy   = 1'b0;
      end
    end else begin
      mbusy = 1'b0;
    end
  end

  // Scoreboard: every ack pulse pops the next expected completion.
  always @(negedge clk) begin
    if (!reset && (cpu_m_ack || mcga_m_ack)) begin
      if (cpu_m_ack) n_cpu++;
      if (mcga_m_ack) n_vga++;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", {30'b0, cpu_m_ack, mcga_m_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {30'b0, cpu_m_ack, mcga_m_ack},
            e.vga ? 32'd1 : 32'd2);
        chk("ack_grant_vga", {31'b0, grant_vga}, {31'b0, e.vga});
        if (e.chk) begin
          chk("ack_rdata",
              {16'b0, e.vga ? mcga_m_data_in : cpu_m_data_in},
              {16'b0, e.data});
        end
      end
    end
  end

  task automatic wait_ack(input bit vga, input int budget);
    int n = 0;
    while (!(vga ? mcga_m_ack : cpu_m_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(vga ? "wait_vga_ack" : "wait_cpu_ack",
        {31'b0, vga ? mcga_m_ack : cpu_m_ack}, 32'd1);
  endtask

  task automatic wait_any(input int budget);
    int n = 0;
    while (!(cpu_m_ack || mcga_m_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_any_ack", {31'b0, cpu_m_ack | mcga_m_ack}, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    int  v0;
    int  cf;
    int  vf;
    bit  expv;

    reset = 1'b1;
    stray_ack = 1'b0;
    mem_ack = 1'b0;
    sdram_m_data_in = 16'h0;
    cpu_m_addr = '0;
    cpu_m_data_out = '0;
    cpu_m_access = 1'b0;
    cpu_m_wr_en = 1'b0;
    cpu_m_bytesel = 2'b11;
    mcga_m_addr = '0;
    mcga_m_data_out = '0;
    mcga_m_access = 1'b0;
    mcga_m_wr_en = 1'b0;
    mcga_m_bytesel = 2'b11;
    vga_active_display = 1'b0;
    mem[19'h01000] = 16'hB5A5;
    mem[19'h00100] = 16'h1111;
    mem[19'h00200] = 16'h2222;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_access", {31'b0, sdram_m_access}, 32'd0);
    chk("rst_cpu_ack", {31'b0, cpu_m_ack}, 32'd0);
    chk("rst_vga_ack", {31'b0, mcga_m_ack}, 32'd0);
    chk("rst_starved", {31'b0, cpu_starved}, 32'd0);
    chk("rst_grant_vga", {31'b0, grant_vga}, 32'd0);
    chk("rst_cpu_data", {16'b0, cpu_m_data_in}, 32'd0);
    chk("rst_vga_data", {16'b0, mcga_m_data_in}, 32'd0);
    chk("rst_addr", {13'b0, sdram_m_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // CPU-only read, 2-cycle memory
    exp_q.push_back('{1'b0, 1'b1, 16'hB5A5});
    v0 = n_vga;
    cpu_m_addr = 19'h01000;
    cpu_m_wr_en = 1'b0;
    cpu_m_access = 1'b1;
    chk("t1_pre_access", {31'b0, sdram_m_access}, 32'd0);
    n = 0;
    do begin
      tick(1);
      n++;
      if (n == 1) begin
        chk("t1_access", {31'b0, sdram_m_access}, 32'd1);
        chk("t1_addr", {13'b0, sdram_m_addr}, 32'h01000);
      end
    end while (!cpu_m_ack && n < 30);
    chk("t1_ack_latency", n, 32'd3);
    cpu_m_access = 1'b0;
    tick(1);
    chk("t1_ack_once", {31'b0, cpu_m_ack}, 32'd0);
    chk("t1_data_hold", {16'b0, cpu_m_data_in}, 32'hB5A5);
    chk("t1_no_vga_ack", n_vga, v0);
    tick(2);

    // CPU write then read back
    exp_q.push_back('{1'b0, 1'b0, 16'h0});
    cpu_m_addr = 19'h12000;
    cpu_m_data_out = 16'hCDAB;
    cpu_m_wr_en = 1'b1;
    cpu_m_bytesel = 2'b11;
    cpu_m_access = 1'b1;
    tick(1);
    chk("t2_wr_en", {31'b0, sdram_m_wr_en}, 32'd1);
    chk("t2_bytesel", {30'b0, sdram_m_bytesel}, 32'd3);
    chk("t2_wdata", {16'b0, sdram_m_data_out}, 32'hCDAB);
    wait_ack(1'b0, 30);
    cpu_m_access = 1'b0;
    tick(3);
    exp_q.push_back('{1'b0, 1'b1, 16'hCDAB});
    cpu_m_wr_en = 1'b0;
    cpu_m_access = 1'b1;
    tick(1);
    chk("t2_rd_access", {31'b0, sdram_m_access}, 32'd1);
    chk("t2_rd_wr_en", {31'b0, sdram_m_wr_en}, 32'd0);
    wait_ack(1'b0, 30);
    cpu_m_access = 1'b0;
    tick(3);

    // Simultaneous requests during active display: VGA first
    vga_active_display = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 16'h1111});
    exp_q.push_back('{1'b0, 1'b1, 16'h2222});
    cpu_m_addr = 19'h00200;
    mcga_m_addr = 19'h00100;
    cpu_m_access = 1'b1;
    mcga_m_access = 1'b1;
    wait_ack(1'b1, 30);
    chk("t3_grant_vga_1", {31'b0, grant_vga}, 32'd1);
    mcga_m_access = 1'b0;
    wait_ack(1'b0, 30);
    chk("t3_grant_vga_0", {31'b0, grant_vga}, 32'd0);
    cpu_m_access = 1'b0;
    tick(3);

    // Ties outside active display alternate; last grant was CPU
    vga_active_display = 1'b0;
    expv = 1'b1;
    cf = 0;
    vf = 0;
    for (int r = 0; r < 10; r++) begin
      exp_q.push_back('{expv, 1'b1, expv ? 16'h1111 : 16'h2222});
      cpu_m_access = 1'b1;
      mcga_m_access = 1'b1;
      wait_any(30);
      if (mcga_m_ack) vf++;
      else if (cpu_m_ack) cf++;
      cpu_m_access = 1'b0;
      mcga_m_access = 1'b0;
      tick(3);
      expv = ~expv;
    end
    chk("t4_cpu_first", cf, 32'd5);
    chk("t4_vga_first", vf, 32'd5);

    // CPU starvation under continuous VGA traffic
    vga_active_display = 1'b1;
    mem_lat = 20;
    exp_q.push_back('{1'b1, 1'b1, 16'h1111});
    exp_q.push_back('{1'b0, 1'b1, 16'h2222});
    mcga_m_access = 1'b1;
    tick(2);
    chk("t5_not_starved", {31'b0, cpu_starved}, 32'd0);
    cpu_m_access = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!cpu_starved && n < 40);
    chk("t5_starve_cycles", n, 32'd12);
    wait_ack(1'b1, 40);
    wait_ack(1'b0, 60);
    chk("t5_grant_cpu", {31'b0, grant_vga}, 32'd0);
    cpu_m_access = 1'b0;
    mcga_m_access = 1'b0;
    tick(1);
    chk("t5_starved_clr", {31'b0, cpu_starved}, 32'd0);
    mem_lat = 2;
    tick(2);

    // Stray memory ack while idle is ignored
    vga_active_display = 1'b0;
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    chk("t6_idle_access", {31'b0, sdram_m_access}, 32'd0);
    tick(3);
    chk("t6_no_cpu_ack", {31'b0, cpu_m_ack}, 32'd0);
    chk("t6_no_vga_ack", {31'b0, mcga_m_ack}, 32'd0);
    exp_q.push_back('{1'b0, 1'b1, 16'hCDAB});
    cpu_m_addr = 19'h12000;
    cpu_m_access = 1'b1;
    wait_ack(1'b0, 30);
    cpu_m_access = 1'b0;
    tick(3);

    // Reset in the middle of a transaction
    mem_lat = 10;
    cpu_m_addr = 19'h01000;
    cpu_m_access = 1'b1;
    tick(2);
    chk("t7_issue_access", {31'b0, sdram_m_access}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("t7_rst_access", {31'b0, sdram_m_access}, 32'd0);
    cpu_m_access = 1'b0;
    tick(1);
    reset = 1'b0;
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    tick(4);
    chk("t7_no_ack", {31'b0, cpu_m_ack}, 32'd0);
    chk("t7_no_access", {31'b0, sdram_m_access}, 32'd0);
    chk("t7_cpu_data_clr", {16'b0, cpu_m_data_in}, 32'd0);
    chk("t7_vga_data_clr", {16'b0, mcga_m_data_in}, 32'd0);
    mem_lat = 2;
    exp_q.push_back('{1'b0, 1'b1, 16'hB5A5});
    cpu_m_access = 1'b1;
    wait_ack(1'b0, 30);
    cpu_m_access = 1'b0;
    tick(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
